// File: rtl/rx_gate_pkg.sv
// Shared types and helpers for the RX payload gate: FSM state encoding,
// word-count constants and the accept (min) calculation.
package rx_gate_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] EN_NONE = 2'd0;
    localparam logic [1:0] EN_ONE  = 2'd1;
    localparam logic [1:0] EN_TWO  = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        FLUSH_WAIT = 2'd2
    } rx_gate_state_e;

    // Smaller of two word counts; used to clip a beat to the words still owed.
    function automatic logic [1:0] min_en(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_gate_flush_timer.sv
// Loadable down-counter: 'load' arms it with FLUSH_DELAY, 'expire' is high
// for the single cycle in which the count sits at 1 (the last wait cycle).
module rx_gate_flush_timer #(
    parameter int FLUSH_DELAY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [3:0] cnt_r;

    // Count down from FLUSH_DELAY once armed, then rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= 4'(FLUSH_DELAY);
        end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == 4'd1);

endmodule

// File: rtl/rx_payload_gate_64.sv
// RX payload gate in front of the 64-bit FIFO packer. Forwards exactly the
// expected number of 32-bit words of a transfer, drops the excess and
// produces the done / error / flush strobes.
// Optional feature: define RX_GATE_DROP_COUNT_EN to build the saturating
// dropped-word counter behind DROP_COUNT (otherwise DROP_COUNT reads 0).
module rx_payload_gate_64 #(
    parameter int FLUSH_DELAY = 2,
    parameter int LEN_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             XFER_START,
    input  logic [LEN_W-1:0] XFER_LEN,
    input  logic             XFER_ABORT,
    input  logic [63:0]      RX_DATA,
    input  logic [1:0]       RX_DATA_EN,
    output logic [63:0]      DATA_OUT,
    output logic [1:0]       DATA_OUT_EN,
    output logic             DATA_OUT_DONE,
    output logic             DATA_OUT_ERR,
    output logic             DATA_OUT_FLUSH,
    output logic             XFER_BUSY,
    output logic [LEN_W-1:0] XFER_WORDS_RECVD,
    output logic             XFER_OVERFLOW,
    output logic [15:0]      DROP_COUNT
);

    import rx_gate_pkg::*;

    rx_gate_state_e   state_r, state_nxt_s;
    logic [LEN_W-1:0] remain_r, remain_nxt_s, words_r, words_nxt_s, remain_dec_s;
    logic [63:0]      data_r, data_nxt_s;
    logic [1:0]       en_r, en_nxt_s;
    logic             done_r, done_nxt_s, err_r, err_nxt_s, flush_r, flush_nxt_s;
    logic             busy_r, busy_nxt_s, ovf_r, ovf_nxt_s;
    logic             illegal_s, load_s, expire_s;
    logic [1:0]       n_s, remain_cap_s, acc_s;

    // A word count of 3 is illegal and carries no data.
    assign illegal_s    = (RX_DATA_EN == 2'd3);
    assign n_s          = illegal_s ? EN_NONE : RX_DATA_EN;
    assign remain_cap_s = (remain_r >= LEN_W'(EN_TWO)) ? EN_TWO : remain_r[1:0];
    assign acc_s        = min_en(n_s, remain_cap_s);
    assign remain_dec_s = remain_r - LEN_W'(acc_s);

    rx_gate_flush_timer #(.FLUSH_DELAY(FLUSH_DELAY)) u_flush_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .load   (load_s),
        .expire (expire_s)
    );

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        words_nxt_s  = words_r;
        busy_nxt_s   = busy_r;
        ovf_nxt_s    = ovf_r;
        data_nxt_s   = 64'd0;
        en_nxt_s     = EN_NONE;
        done_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        flush_nxt_s  = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (XFER_START) begin
                    remain_nxt_s = XFER_LEN;
                    words_nxt_s  = {LEN_W{1'b0}};
                    ovf_nxt_s    = (n_s != EN_NONE);
                    busy_nxt_s   = 1'b1;
                    if (XFER_LEN == {LEN_W{1'b0}}) begin
                        done_nxt_s  = 1'b1;
                        load_s      = 1'b1;
                        state_nxt_s = FLUSH_WAIT;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end else if (n_s != EN_NONE) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
            end
            ACTIVE: begin
                if (XFER_ABORT) begin
                    // Abort wins: the beat of this cycle is discarded.
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                    load_s      = 1'b1;
                    state_nxt_s = FLUSH_WAIT;
                end else begin
                    err_nxt_s    = illegal_s;
                    en_nxt_s     = acc_s;
                    remain_nxt_s = remain_dec_s;
                    words_nxt_s  = words_r + LEN_W'(acc_s);
                    case (acc_s)
                        EN_TWO:  data_nxt_s = RX_DATA;
                        EN_ONE:  data_nxt_s = {{WORD_W{1'b0}}, RX_DATA[WORD_W-1:0]};
                        default: data_nxt_s = 64'd0;
                    endcase
                    if (n_s > acc_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        ovf_nxt_s = ovf_r;
                    end
                    if (remain_dec_s == {LEN_W{1'b0}}) begin
                        done_nxt_s  = 1'b1;
                        load_s      = 1'b1;
                        state_nxt_s = FLUSH_WAIT;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (n_s != EN_NONE) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
                if (expire_s) begin
                    flush_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FLUSH_WAIT;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            remain_r <= {LEN_W{1'b0}};
            words_r  <= {LEN_W{1'b0}};
            busy_r   <= 1'b0;
            ovf_r    <= 1'b0;
            data_r   <= 64'd0;
            en_r     <= EN_NONE;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            flush_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            remain_r <= remain_nxt_s;
            words_r  <= words_nxt_s;
            busy_r   <= busy_nxt_s;
            ovf_r    <= ovf_nxt_s;
            data_r   <= data_nxt_s;
            en_r     <= en_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            flush_r  <= flush_nxt_s;
        end
    end

    assign DATA_OUT         = data_r;
    assign DATA_OUT_EN      = en_r;
    assign DATA_OUT_DONE    = done_r;
    assign DATA_OUT_ERR     = err_r;
    assign DATA_OUT_FLUSH   = flush_r;
    assign XFER_BUSY        = busy_r;
    assign XFER_WORDS_RECVD = words_r;
    assign XFER_OVERFLOW    = ovf_r;

`ifdef RX_GATE_DROP_COUNT_EN
    logic [1:0]  drop_w_s;
    logic        clr_drop_s;
    logic [15:0] drop_r, drop_nxt_s;
    logic [16:0] drop_sum_s;

    // Words discarded by this beat, and whether an accepted start restarts the count.
    always_comb begin
        drop_w_s   = EN_NONE;
        clr_drop_s = 1'b0;
        case (state_r)
            IDLE: begin
                drop_w_s   = n_s;
                clr_drop_s = XFER_START;
            end
            ACTIVE: begin
                if (XFER_ABORT) begin
                    drop_w_s = EN_NONE;
                end else begin
                    drop_w_s = n_s - acc_s;
                end
            end
            FLUSH_WAIT: drop_w_s = n_s;
            default:    drop_w_s = EN_NONE;
        endcase
    end

    assign drop_sum_s = {1'b0, drop_r} + {15'd0, drop_w_s};

    // Saturating accumulate; a start clears the history before counting its own beat.
    always_comb begin
        if (clr_drop_s) begin
            drop_nxt_s = {14'd0, drop_w_s};
        end else if (drop_sum_s[16]) begin
            drop_nxt_s = 16'hFFFF;
        end else begin
            drop_nxt_s = drop_sum_s[15:0];
        end
    end

    // Dropped-word counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_r <= 16'd0;
        end else begin
            drop_r <= drop_nxt_s;
        end
    end

    assign DROP_COUNT = drop_r;
`else
    assign DROP_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_rx_payload_gate_64.sv
// Scoreboard bench for rx_payload_gate_64: a transaction-level reference
// model predicts output events and status; a monitor compares them.
module tb_rx_payload_gate_64;

    localparam int FD = 2;
    localparam int LW = 32;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          XFER_START = 1'b0;
    logic [LW-1:0] XFER_LEN = '0;
    logic          XFER_ABORT = 1'b0;
    logic [63:0]   RX_DATA = '0;
    logic [1:0]    RX_DATA_EN = '0;
    logic [63:0]   DATA_OUT;
    logic [1:0]    DATA_OUT_EN;
    logic          DATA_OUT_DONE, DATA_OUT_ERR, DATA_OUT_FLUSH, XFER_BUSY, XFER_OVERFLOW;
    logic [LW-1:0] XFER_WORDS_RECVD;
    logic [15:0]   DROP_COUNT;

    rx_payload_gate_64 #(.FLUSH_DELAY(FD), .LEN_W(LW)) dut (
        .CLK(CLK), .RST_N(RST_N), .XFER_START(XFER_START), .XFER_LEN(XFER_LEN),
        .XFER_ABORT(XFER_ABORT), .RX_DATA(RX_DATA), .RX_DATA_EN(RX_DATA_EN),
        .DATA_OUT(DATA_OUT), .DATA_OUT_EN(DATA_OUT_EN), .DATA_OUT_DONE(DATA_OUT_DONE),
        .DATA_OUT_ERR(DATA_OUT_ERR), .DATA_OUT_FLUSH(DATA_OUT_FLUSH), .XFER_BUSY(XFER_BUSY),
        .XFER_WORDS_RECVD(XFER_WORDS_RECVD), .XFER_OVERFLOW(XFER_OVERFLOW),
        .DROP_COUNT(DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          edge_no;
        logic [63:0] data;
        logic [1:0]  en;
        bit          done;
        bit          err;
        bit          flush;
    } ev_t;

    ev_t q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  edge_cnt = 0;

    // Reference model: transfer-level bookkeeping.
    bit          m_busy = 0, m_collect = 0, m_ovf = 0, m_side_ok = 1;
    int          m_rem = 0, m_drop = 0, m_flush_edge = -1;
    logic [31:0] m_words = '0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_collect = 0; m_ovf = 0; m_side_ok = 1;
        m_rem = 0; m_drop = 0; m_flush_edge = -1; m_words = '0;
    endtask

    // Predict what the gate does with one cycle of inputs at clock edge 'cyc'.
    task automatic model_edge(input bit st, input int len, input bit ab,
                              input logic [63:0] d, input logic [1:0] e, input int cyc);
        ev_t ev;
        int n, acc;
        n = (e == 2'd3) ? 0 : int'(e);
        ev.edge_no = cyc; ev.data = 64'd0; ev.en = 2'd0;
        ev.done = 0; ev.err = 0; ev.flush = 0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_rem = len; m_words = '0; m_side_ok = 1;
                m_ovf = (n != 0); m_drop = n;
                if (len == 0) begin
                    ev.done = 1; m_collect = 0; m_flush_edge = cyc + FD;
                end else begin
                    m_collect = 1;
                end
            end else begin
                if (n != 0) m_ovf = 1;
                m_drop = sat16(m_drop + n);
            end
        end else if (m_collect) begin
            if (ab) begin
                ev.done = 1; ev.err = 1; m_collect = 0; m_flush_edge = cyc + FD;
                if (n != 0) m_side_ok = 0;
            end else begin
                acc = (n < m_rem) ? n : m_rem;
                ev.err = (e == 2'd3);
                ev.en = 2'(acc);
                ev.data = (acc == 2) ? d : (acc == 1) ? {32'd0, d[31:0]} : 64'd0;
                m_rem = m_rem - acc;
                m_words = m_words + 32'(acc);
                if (n > acc) begin
                    m_ovf = 1; m_drop = sat16(m_drop + n - acc);
                end
                if (m_rem == 0) begin
                    ev.done = 1; m_collect = 0; m_flush_edge = cyc + FD;
                end
            end
        end else begin
            if (n != 0) m_ovf = 1;
            m_drop = sat16(m_drop + n);
            if (cyc == m_flush_edge) begin
                ev.flush = 1; m_busy = 0;
            end
        end
        if (ev.en != 2'd0 || ev.done || ev.err || ev.flush) q.push_back(ev);
    endtask

    // Status outputs against the model after each clock.
    task automatic check_status();
        logic [15:0] exp_drop;
`ifdef RX_GATE_DROP_COUNT_EN
        exp_drop = 16'(m_drop);
`else
        exp_drop = 16'd0;
`endif
        compared++;
        if (XFER_BUSY !== m_busy || XFER_WORDS_RECVD !== m_words ||
            (m_side_ok && (XFER_OVERFLOW !== m_ovf || DROP_COUNT !== exp_drop))) begin
            mismatched++;
            $display("FAIL status t=%0t: got busy=%0b words=%0d ovf=%0b drop=%0d, want busy=%0b words=%0d ovf=%0b drop=%0d",
                     $time, XFER_BUSY, XFER_WORDS_RECVD, XFER_OVERFLOW, DROP_COUNT,
                     m_busy, m_words, m_ovf, exp_drop);
        end
    endtask

    task automatic check_reset(input string name);
        compared++;
        if ({DATA_OUT, DATA_OUT_EN, DATA_OUT_DONE, DATA_OUT_ERR, DATA_OUT_FLUSH, XFER_BUSY,
             XFER_WORDS_RECVD, XFER_OVERFLOW, DROP_COUNT} !== '0) begin
            mismatched++;
            $display("FAIL %s: got data=%h en=%0d done=%0b err=%0b flush=%0b busy=%0b words=%0d ovf=%0b drop=%0d, want all zero",
                     name, DATA_OUT, DATA_OUT_EN, DATA_OUT_DONE, DATA_OUT_ERR, DATA_OUT_FLUSH,
                     XFER_BUSY, XFER_WORDS_RECVD, XFER_OVERFLOW, DROP_COUNT);
        end
    endtask

    // One clock of stimulus: called at a falling edge, returns at the next one.
    task automatic step(input bit st, input int len, input bit ab,
                        input logic [63:0] d, input logic [1:0] e);
        XFER_START = st; XFER_LEN = 32'(len); XFER_ABORT = ab;
        RX_DATA = d; RX_DATA_EN = e;
        model_edge(st, len, ab, d, e, edge_cnt + 1);
        @(negedge CLK);
        check_status();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 64'd0, 2'd0);
    endtask

    task automatic beat(input logic [63:0] d, input logic [1:0] e);
        step(0, 0, 0, d, e);
    endtask

    // Monitor: compare every presented output event with the scoreboard.
    always @(negedge CLK) begin
        ev_t x;
        bit  pres;
        pres = (DATA_OUT_EN != 2'd0) || DATA_OUT_DONE || DATA_OUT_ERR || DATA_OUT_FLUSH;
        if (pres || (q.size() > 0 && q[0].edge_no <= edge_cnt)) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event edge=%0d: got data=%h en=%0d done=%0b err=%0b flush=%0b, want no event",
                         edge_cnt, DATA_OUT, DATA_OUT_EN, DATA_OUT_DONE, DATA_OUT_ERR, DATA_OUT_FLUSH);
            end else begin
                x = q.pop_front();
                if (x.edge_no != edge_cnt || DATA_OUT !== x.data || DATA_OUT_EN !== x.en ||
                    DATA_OUT_DONE !== x.done || DATA_OUT_ERR !== x.err || DATA_OUT_FLUSH !== x.flush) begin
                    mismatched++;
                    $display("FAIL event edge=%0d: got data=%h en=%0d done=%0b err=%0b flush=%0b, want edge=%0d data=%h en=%0d done=%0b err=%0b flush=%0b",
                             edge_cnt, DATA_OUT, DATA_OUT_EN, DATA_OUT_DONE, DATA_OUT_ERR, DATA_OUT_FLUSH,
                             x.edge_no, x.data, x.en, x.done, x.err, x.flush);
                end
            end
        end
    end

    initial begin
        int r;
        logic [1:0] e;
        bit st;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset("reset_state");
        model_reset();
        RST_N = 1'b1;

        // Length 5, three full beats: 2,2,1 accepted, one word dropped.
        step(1, 5, 0, 64'd0, 2'd0);
        beat(64'h00001111_00000000, 2'd2);
        beat(64'h00003333_00002222, 2'd2);
        beat(64'h00005555_00004444, 2'd2);
        idle(FD + 2);

        // Zero-length transfer.
        step(1, 0, 0, 64'd0, 2'd0);
        idle(FD + 2);

        // Abort together with a beat.
        step(1, 8, 0, 64'd0, 2'd0);
        beat(64'hAAAA0001_BBBB0002, 2'd2);
        beat(64'hAAAA0003_BBBB0004, 2'd2);
        step(0, 0, 1, 64'hAAAA0005_BBBB0006, 2'd2);
        idle(FD + 2);

        // Second start while busy is ignored.
        step(1, 4, 0, 64'd0, 2'd0);
        step(1, 9, 0, 64'h12345678_9ABCDEF0, 2'd2);
        beat(64'h0F0F0F0F_F0F0F0F0, 2'd2);
        beat(64'hDEADBEEF_CAFEF00D, 2'd2);
        idle(FD + 2);

        // Illegal word count, then normal completion.
        step(1, 3, 0, 64'd0, 2'd0);
        beat(64'h11111111_22222222, 2'd3);
        beat(64'h33333333_44444444, 2'd2);
        beat(64'h55555555_66666666, 2'd2);
        idle(FD + 2);

        // Dropped words: 3 excess plus 2 in idle, then cleared by a start.
        step(1, 3, 0, 64'd0, 2'd0);
        beat(64'h01010101_02020202, 2'd2);
        beat(64'h03030303_04040404, 2'd2);
        beat(64'h05050505_06060606, 2'd2);
        idle(FD + 2);
        beat(64'h07070707_08080808, 2'd2);
        step(1, 2, 0, 64'd0, 2'd0);
        beat(64'h09090909_0A0A0A0A, 2'd2);
        idle(FD + 2);

        // Reset in the middle of a transfer: no done, no flush afterwards.
        step(1, 6, 0, 64'd0, 2'd0);
        beat(64'hFEEDFACE_01234567, 2'd2);
        XFER_START = 1'b0; RX_DATA_EN = 2'd0;
        #2 RST_N = 1'b0;
        #1 check_reset("async_reset");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        idle(FD + 4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            st = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 19));
            e = (r < 6) ? 2'd0 : (r < 12) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            step(st, int'($urandom_range(0, 12)), ($urandom_range(0, 30) == 0),
                 {$urandom, $urandom}, e);
        end
        idle(FD + 4);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_events: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
